// File: rtl/compute_core_feeder_if.sv
// Bundle between the buffer readers / core and compute_core_feeder.
// With CCF_WEIGHT_REUSE_EN defined the command also carries cmd_reuse_w.
interface compute_core_feeder_if #(
    parameter int SIZE       = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ROW_CNT_W  = 16
);
    logic                         cmd_valid;
    logic                         cmd_ready;
    logic [ROW_CNT_W-1:0]         cmd_rows;
    logic                         cmd_is_init;
    logic [SIZE*32-1:0]           cmd_bias;
`ifdef CCF_WEIGHT_REUSE_EN
    logic                         cmd_reuse_w;
`endif
    logic                         w_valid;
    logic                         w_ready;
    logic [SIZE*8-1:0]            w_row;
    logic                         ia_valid;
    logic                         ia_ready;
    logic [SIZE*DATA_WIDTH-1:0]   ia_row;
    logic                         store_weight_req;
    logic [SIZE*8-1:0]            weight_in;
    logic [SIZE*DATA_WIDTH-1:0]   ia_vec_in;
    logic                         ia_row_valid;
    logic                         ia_calc_done;
    logic                         ia_is_init_data;
    logic [SIZE*32-1:0]           bias_in;
    logic                         tile_calc_over;
    logic                         busy;
    logic                         tile_done;

    modport master (
        output cmd_valid, cmd_rows, cmd_is_init, cmd_bias,
`ifdef CCF_WEIGHT_REUSE_EN
        output cmd_reuse_w,
`endif
        output w_valid, w_row, ia_valid, ia_row, tile_calc_over,
        input  cmd_ready, w_ready, ia_ready, store_weight_req, weight_in,
        input  ia_vec_in, ia_row_valid, ia_calc_done, ia_is_init_data, bias_in,
        input  busy, tile_done
    );

    modport slave (
        input  cmd_valid, cmd_rows, cmd_is_init, cmd_bias,
`ifdef CCF_WEIGHT_REUSE_EN
        input  cmd_reuse_w,
`endif
        input  w_valid, w_row, ia_valid, ia_row, tile_calc_over,
        output cmd_ready, w_ready, ia_ready, store_weight_req, weight_in,
        output ia_vec_in, ia_row_valid, ia_calc_done, ia_is_init_data, bias_in,
        output busy, tile_done
    );
endinterface

// File: rtl/compute_core_feeder.sv
// Transmit side of the compute_core input protocol: one tile command, SIZE weight rows,
// then the IA rows. Optional weight reuse is enabled by defining CCF_WEIGHT_REUSE_EN.
module compute_core_feeder #(
    parameter int SIZE       = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ROW_CNT_W  = 16
) (
    input logic                  clk,
    input logic                  rst,
    compute_core_feeder_if.slave bus
);
    localparam int WCNT_W = (SIZE > 1) ? $clog2(SIZE) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD_W, S_STREAM, S_WAIT} state_t;

    state_t               state;
    logic [WCNT_W-1:0]    wcnt;
    logic [ROW_CNT_W-1:0] rcnt;
    logic [ROW_CNT_W-1:0] rows;

`ifdef CCF_WEIGHT_REUSE_EN
    // Weights survive in the core only once a full set has gone in since reset.
    logic w_loaded;
    logic skip_w;
    assign skip_w = bus.cmd_reuse_w && w_loaded;
`endif

    // Ready flags are registered from the next state, so every output is 0 in reset
    // and cmd_ready rises on the first edge after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                <= S_IDLE;
            wcnt                 <= '0;
            rcnt                 <= '0;
            rows                 <= '0;
            bus.cmd_ready        <= 1'b0;
            bus.w_ready          <= 1'b0;
            bus.ia_ready         <= 1'b0;
            bus.store_weight_req <= 1'b0;
            bus.weight_in        <= '0;
            bus.ia_vec_in        <= '0;
            bus.ia_row_valid     <= 1'b0;
            bus.ia_calc_done     <= 1'b0;
            bus.ia_is_init_data  <= 1'b0;
            bus.bias_in          <= '0;
            bus.busy             <= 1'b0;
            bus.tile_done        <= 1'b0;
`ifdef CCF_WEIGHT_REUSE_EN
            w_loaded             <= 1'b0;
`endif
        end else begin
            bus.store_weight_req <= 1'b0;
            bus.ia_row_valid     <= 1'b0;
            bus.ia_calc_done     <= 1'b0;
            bus.tile_done        <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        rows                <= bus.cmd_rows;
                        bus.ia_is_init_data <= bus.cmd_is_init;
                        bus.bias_in         <= bus.cmd_bias;
                        rcnt                <= '0;
                        wcnt                <= '0;
                        if (bus.cmd_rows == '0) begin
                            // Empty tile: nothing reaches the core, just report completion.
                            bus.tile_done <= 1'b1;
                        end
`ifdef CCF_WEIGHT_REUSE_EN
                        else if (skip_w) begin
                            state         <= S_STREAM;
                            bus.cmd_ready <= 1'b0;
                            bus.ia_ready  <= 1'b1;
                            bus.busy      <= 1'b1;
                        end
`endif
                        else begin
                            state         <= S_LOAD_W;
                            bus.cmd_ready <= 1'b0;
                            bus.w_ready   <= 1'b1;
                            bus.busy      <= 1'b1;
                        end
                    end else begin
                        bus.cmd_ready <= 1'b1;
                    end
                end
                S_LOAD_W: begin
                    if (bus.w_valid && bus.w_ready) begin
                        bus.store_weight_req <= 1'b1;
                        bus.weight_in        <= bus.w_row;
                        wcnt                 <= wcnt + WCNT_W'(1);
                        if (wcnt == WCNT_W'(SIZE - 1)) begin
                            state        <= S_STREAM;
                            bus.w_ready  <= 1'b0;
                            bus.ia_ready <= 1'b1;
`ifdef CCF_WEIGHT_REUSE_EN
                            w_loaded     <= 1'b1;
`endif
                        end
                    end
                end
                S_STREAM: begin
                    if (bus.ia_valid && bus.ia_ready) begin
                        bus.ia_row_valid <= 1'b1;
                        bus.ia_vec_in    <= bus.ia_row;
                        rcnt             <= rcnt + ROW_CNT_W'(1);
                        // rows is nonzero here, so rows-1 never underflows.
                        if (rcnt == rows - ROW_CNT_W'(1)) begin
                            bus.ia_calc_done <= 1'b1;
                            bus.ia_ready     <= 1'b0;
                            state            <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (bus.tile_calc_over) begin
                        state         <= S_IDLE;
                        bus.tile_done <= 1'b1;
                        bus.busy      <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_compute_core_feeder.sv
// Directed bench for compute_core_feeder: weight/IA beats go into scoreboard queues
// at handshake time and are checked against the core-side outputs on the falling edge.
module tb_compute_core_feeder;
    localparam int SIZE = 4;
    localparam int DW   = 16;
    localparam int RW   = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    compute_core_feeder_if #(.SIZE(SIZE), .DATA_WIDTH(DW), .ROW_CNT_W(RW)) bus ();
    compute_core_feeder #(.SIZE(SIZE), .DATA_WIDTH(DW), .ROW_CNT_W(RW)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    typedef struct {
        logic [SIZE*DW-1:0] vec;
        logic               last;
    } ia_exp_t;

    int n_checks = 0;
    int n_fail   = 0;
    int sw_cnt   = 0;
    int irv_cnt  = 0;
    int cd_cnt   = 0;

    logic [SIZE*8-1:0]  w_q[$];
    ia_exp_t            ia_q[$];
    logic [SIZE*32-1:0] exp_bias;
    logic               exp_init;
    logic [SIZE*8-1:0]  mon_w;
    ia_exp_t            mon_ia;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Core-side monitor / scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.store_weight_req) begin
                sw_cnt++;
                chk("w_unexpected", w_q.size() != 0, 1);
                if (w_q.size() != 0) begin
                    mon_w = w_q.pop_front();
                    chk("weight_in", bus.weight_in, mon_w);
                end
            end
            if (bus.ia_row_valid) begin
                irv_cnt++;
                chk("ia_unexpected", ia_q.size() != 0, 1);
                if (ia_q.size() != 0) begin
                    mon_ia = ia_q.pop_front();
                    chk("ia_vec_in", bus.ia_vec_in, mon_ia.vec);
                    chk("ia_calc_done", bus.ia_calc_done, mon_ia.last);
                end
                chk("bias_in", bus.bias_in, exp_bias);
                chk("ia_is_init_data", bus.ia_is_init_data, exp_init);
            end
            if (bus.ia_calc_done) cd_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cmd_ready"}, bus.cmd_ready, 0);
        chk({tag, "_w_ready"}, bus.w_ready, 0);
        chk({tag, "_ia_ready"}, bus.ia_ready, 0);
        chk({tag, "_store_weight_req"}, bus.store_weight_req, 0);
        chk({tag, "_weight_in"}, bus.weight_in, 0);
        chk({tag, "_ia_vec_in"}, bus.ia_vec_in, 0);
        chk({tag, "_ia_row_valid"}, bus.ia_row_valid, 0);
        chk({tag, "_ia_calc_done"}, bus.ia_calc_done, 0);
        chk({tag, "_ia_is_init_data"}, bus.ia_is_init_data, 0);
        chk({tag, "_bias_in"}, bus.bias_in, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_tile_done"}, bus.tile_done, 0);
    endtask

    task automatic send_cmd(input int rows, input bit init, input logic [SIZE*32-1:0] bias);
        bit ok;
        int t = 0;
        exp_bias        = bias;
        exp_init        = init;
        bus.cmd_valid   = 1'b1;
        bus.cmd_rows    = RW'(rows);
        bus.cmd_is_init = init;
        bus.cmd_bias    = bias;
        do begin
            @(negedge clk);
            ok = bus.cmd_ready;
            tick();
            t++;
        end while (!ok && t < 100);
        chk("cmd_accept", ok, 1);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic send_w(input logic [SIZE*8-1:0] row, input int gap);
        bit ok;
        int t = 0;
        bus.w_valid = 1'b1;
        bus.w_row   = row;
        do begin
            @(negedge clk);
            ok = bus.w_ready;
            tick();
            t++;
        end while (!ok && t < 100);
        chk("w_handshake", ok, 1);
        if (ok) w_q.push_back(row);
        bus.w_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_ia(input logic [SIZE*DW-1:0] row, input bit last, input int gap);
        bit ok;
        int t = 0;
        bus.ia_valid = 1'b1;
        bus.ia_row   = row;
        do begin
            @(negedge clk);
            ok = bus.ia_ready;
            tick();
            t++;
        end while (!ok && t < 100);
        chk("ia_handshake", ok, 1);
        if (ok) ia_q.push_back('{vec: row, last: last});
        bus.ia_valid = 1'b0;
        repeat (gap) tick();
    endtask

    // Holds off tile_calc_over for wait_c cycles, then pulses it once.
    task automatic finish_tile(input int wait_c);
        repeat (wait_c) begin
            @(negedge clk);
            chk("wait_cmd_ready", bus.cmd_ready, 0);
            chk("wait_tile_done", bus.tile_done, 0);
            chk("wait_busy", bus.busy, 1);
            tick();
        end
        bus.tile_calc_over = 1'b1;
        tick();
        bus.tile_calc_over = 1'b0;
        @(negedge clk);
        chk("tile_done_pulse", bus.tile_done, 1);
        chk("cmd_ready_back", bus.cmd_ready, 1);
        chk("busy_clear", bus.busy, 0);
        tick();
        @(negedge clk);
        chk("tile_done_single", bus.tile_done, 0);
        tick();
    endtask

    task automatic tile_counts(input int e_sw, input int e_irv, input int e_cd);
        chk("store_weight_req_count", sw_cnt, e_sw);
        chk("ia_row_valid_count", irv_cnt, e_irv);
        chk("ia_calc_done_count", cd_cnt, e_cd);
        chk("w_q_drained", w_q.size(), 0);
        chk("ia_q_drained", ia_q.size(), 0);
        sw_cnt  = 0;
        irv_cnt = 0;
        cd_cnt  = 0;
    endtask

    task automatic run_tile(input int rows, input bit init, input logic [SIZE*32-1:0] bias,
                            input int gap, input int wait_c);
        send_cmd(rows, init, bias);
        for (int i = 0; i < SIZE; i++) send_w($urandom, gap);
        for (int i = 0; i < rows; i++) send_ia({$urandom, $urandom}, i == rows - 1, gap);
        finish_tile(wait_c);
        tile_counts(SIZE, rows, 1);
    endtask

    function automatic logic [SIZE*32-1:0] rand_bias();
        logic [SIZE*32-1:0] b;
        for (int i = 0; i < SIZE; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    initial begin
        logic [SIZE*32-1:0] b1234;
        logic [SIZE*DW-1:0] r;
        bus.cmd_valid      = 1'b0;
        bus.cmd_rows       = '0;
        bus.cmd_is_init    = 1'b0;
        bus.cmd_bias       = '0;
        bus.w_valid        = 1'b0;
        bus.w_row          = '0;
        bus.ia_valid       = 1'b0;
        bus.ia_row         = '0;
        bus.tile_calc_over = 1'b0;
`ifdef CCF_WEIGHT_REUSE_EN
        bus.cmd_reuse_w    = 1'b0;
`endif
        for (int i = 0; i < SIZE; i++) b1234[32*i +: 32] = 32'(i + 1);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        tick();
        rst = 1'b0;

        // Basic tile, no stalls
        run_tile(3, 1'b1, b1234, 0, 0);

        // Same tile with valid toggling 1-0-1
        run_tile(3, 1'b1, b1234, 1, 0);

        // Empty tile
        send_cmd(0, 1'b0, rand_bias());
        @(negedge clk);
        chk("empty_tile_done", bus.tile_done, 1);
        chk("empty_busy", bus.busy, 0);
        tick();
        @(negedge clk);
        chk("empty_tile_done_single", bus.tile_done, 0);
        tick();
        repeat (3) tick();
        tile_counts(0, 0, 0);

        // tile_calc_over pulse during STREAM is ignored; WAIT held for 10 cycles
        send_cmd(2, 1'b0, rand_bias());
        for (int i = 0; i < SIZE; i++) send_w($urandom, 0);
        send_ia({$urandom, $urandom}, 1'b0, 0);
        bus.tile_calc_over = 1'b1;
        tick();
        bus.tile_calc_over = 1'b0;
        @(negedge clk);
        chk("stream_tco_busy", bus.busy, 1);
        chk("stream_tco_tile_done", bus.tile_done, 0);
        chk("stream_tco_ia_ready", bus.ia_ready, 1);
        tick();
        send_ia({$urandom, $urandom}, 1'b1, 0);
        finish_tile(10);
        tile_counts(SIZE, 2, 1);

        // Reset mid-STREAM after 2 of 5 rows
        send_cmd(5, 1'b1, rand_bias());
        for (int i = 0; i < SIZE; i++) send_w($urandom, 0);
        send_ia({$urandom, $urandom}, 1'b0, 0);
        send_ia({$urandom, $urandom}, 1'b0, 0);
        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk_all_zero("midreset");
        tile_counts(SIZE, 2, 0);
        tick();
        rst = 1'b0;
        run_tile(1, 1'b0, rand_bias(), 0, 0);

`ifdef CCF_WEIGHT_REUSE_EN
        // Weight reuse: second tile skips LOAD_W
        run_tile(2, 1'b1, rand_bias(), 0, 0);
        r = {$urandom, $urandom};
        bus.ia_valid = 1'b1;
        bus.ia_row   = r;
        ia_q.push_back('{vec: r, last: 1'b1});
        bus.cmd_reuse_w = 1'b1;
        send_cmd(1, 1'b0, rand_bias());
        bus.cmd_reuse_w = 1'b0;
        tick();
        bus.ia_valid = 1'b0;
        @(negedge clk);
        chk("reuse_first_ia_latency", bus.ia_row_valid, 1);
        tick();
        finish_tile(0);
        tile_counts(0, 1, 1);
`else
        r = '0;
        bus.ia_row = r;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
